// File: rtl/cafe_pkg.sv
// Shared types, recipe table and helper functions for the coffee dispensing sequencer.
package cafe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAFE  = 3'd1,
    AGUA  = 3'd2,
    LECHE = 3'd3,
    CHOCO = 3'd4,
    LISTO = 3'd5
  } estado_t;

  typedef logic [1:0] bebida_t;

  localparam int RECETA_W = 4;

  // Rows indexed by drink code, columns {cafe, agua, leche, choco} in time units.
  localparam logic [RECETA_W-1:0] RECETA [4][4] = '{
    '{4'd3, 4'd2, 4'd0, 4'd0},
    '{4'd3, 4'd0, 4'd3, 4'd0},
    '{4'd3, 4'd1, 4'd2, 4'd0},
    '{4'd3, 4'd0, 4'd2, 4'd2}
  };

  function automatic logic es_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  function automatic bebida_t onehot_a_codigo(input logic [3:0] s);
    bebida_t r;
    case (s)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // First phase at or after index 'desde' with a non-zero duration; LISTO if none remain.
  function automatic estado_t siguiente_fase(input bebida_t b, input logic [2:0] desde);
    estado_t r;
    r = LISTO;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(desde)) && (RECETA[b][i] != '0)) r = estado_t'(3'(i + 1));
    end
    return r;
  endfunction

  function automatic logic [RECETA_W-1:0] duracion(input bebida_t b, input estado_t e);
    logic [RECETA_W-1:0] r;
    case (e)
      CAFE:    r = RECETA[b][0];
      AGUA:    r = RECETA[b][1];
      LECHE:   r = RECETA[b][2];
      CHOCO:   r = RECETA[b][3];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cafe_prescaler.sv
// Divides the clock by TICK_DIV; emits a one-cycle tick, with synchronous clear and enable.
module cafe_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == ULTIMO);

endmodule

// File: rtl/cafe_dispensador.sv
// Timed valve sequencer for four drink recipes. Optional cup sensor with pause/resume
// is enabled by defining CAFE_TAZA_EN.
module cafe_dispensador
  import cafe_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DUR_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aceptada,
  input  logic [3:0] seleccion,
  input  logic       cancelar,
`ifdef CAFE_TAZA_EN
  input  logic       taza_presente,
`endif
  output logic       valvula_cafe,
  output logic       valvula_agua,
  output logic       valvula_leche,
  output logic       valvula_choco,
  output logic       ocupado,
  output logic       listo,
  output logic       rechazo,
  output logic [1:0] bebida_actual,
  output estado_t    estado_dbg_o
);

  logic taza;
`ifdef CAFE_TAZA_EN
  assign taza = taza_presente;
`else
  assign taza = 1'b1;
`endif

  estado_t          estado_q, estado_d;
  bebida_t          bebida_q, bebida_d;
  logic             rechazo_q, rechazo_d;
  logic [DUR_W-1:0] unid_q, unid_d;
  logic [DUR_W-1:0] dur;
  logic             en_fase, corre, clr, tick, fin_fase;

  assign en_fase  = (estado_q == CAFE) || (estado_q == AGUA) ||
                    (estado_q == LECHE) || (estado_q == CHOCO);
  // A missing cup freezes both timers and closes every valve while the state holds.
  assign corre    = en_fase && taza;
  assign clr      = (estado_d != estado_q);
  assign dur      = DUR_W'(duracion(bebida_q, estado_q));
  assign fin_fase = tick && (unid_q == (dur - DUR_W'(1)));

  cafe_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .en_i   (corre),
    .tick_o (tick)
  );

  always_comb begin
    estado_d  = estado_q;
    bebida_d  = bebida_q;
    rechazo_d = 1'b0;
    if (estado_q == IDLE) begin
      if (aceptada) begin
        if (cancelar || !es_onehot(seleccion) || !taza) begin
          rechazo_d = 1'b1;
        end else begin
          bebida_d = onehot_a_codigo(seleccion);
          estado_d = siguiente_fase(bebida_d, 3'd0);
        end
      end
    end else begin
      rechazo_d = aceptada;
      if (cancelar)                estado_d = IDLE;
      else if (estado_q == LISTO)  estado_d = IDLE;
      // Phase index of the state after the current one equals the current encoding.
      else if (fin_fase)           estado_d = siguiente_fase(bebida_q, estado_q);
    end
  end

  always_comb begin
    unid_d = unid_q;
    if (clr)       unid_d = '0;
    else if (tick) unid_d = unid_q + DUR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= IDLE;
      bebida_q  <= '0;
      rechazo_q <= 1'b0;
      unid_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      bebida_q  <= bebida_d;
      rechazo_q <= rechazo_d;
      unid_q    <= unid_d;
    end
  end

  assign valvula_cafe  = (estado_q == CAFE)  && taza;
  assign valvula_agua  = (estado_q == AGUA)  && taza;
  assign valvula_leche = (estado_q == LECHE) && taza;
  assign valvula_choco = (estado_q == CHOCO) && taza;
  assign ocupado       = (estado_q != IDLE);
  assign listo         = (estado_q == LISTO);
  assign rechazo       = rechazo_q;
  assign bebida_actual = ocupado ? bebida_q : 2'd0;
  assign estado_dbg_o  = estado_q;

endmodule

// File: tb/tb_cafe_dispensador.sv
// Directed bench for cafe_dispensador with TICK_DIV=2; cup-sensor steps build with CAFE_TAZA_EN.
module tb_cafe_dispensador;
  import cafe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       aceptada = 1'b0;
  logic [3:0] seleccion = 4'b0000;
  logic       cancelar = 1'b0;
`ifdef CAFE_TAZA_EN
  logic       taza_presente = 1'b1;
`endif
  logic       valvula_cafe, valvula_agua, valvula_leche, valvula_choco;
  logic       ocupado, listo, rechazo;
  logic [1:0] bebida_actual;
  estado_t    estado_dbg;

  int checks = 0;
  int errors = 0;

  // Hand-entered recipes {cafe, agua, leche, choco} in time units.
  int tb_rec [4][4] = '{'{3, 2, 0, 0}, '{3, 0, 3, 0}, '{3, 1, 2, 0}, '{3, 0, 2, 2}};

  cafe_dispensador #(.TICK_DIV(2), .DUR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .aceptada      (aceptada),
    .seleccion     (seleccion),
    .cancelar      (cancelar),
`ifdef CAFE_TAZA_EN
    .taza_presente (taza_presente),
`endif
    .valvula_cafe  (valvula_cafe),
    .valvula_agua  (valvula_agua),
    .valvula_leche (valvula_leche),
    .valvula_choco (valvula_choco),
    .ocupado       (ocupado),
    .listo         (listo),
    .rechazo       (rechazo),
    .bebida_actual (bebida_actual),
    .estado_dbg_o  (estado_dbg)
  );

  always #5 clk = ~clk;

  // Bit order: {cafe, agua, leche, choco, ocupado, listo, rechazo}
  function automatic logic [6:0] salidas();
    return {valvula_cafe, valvula_agua, valvula_leche, valvula_choco, ocupado, listo, rechazo};
  endfunction

  // Expected {cafe, agua, leche, choco, ocupado, listo} at cycle c after acceptance at edge 0.
  function automatic logic [5:0] modelo(input int b, input int c);
    logic [5:0] r;
    int t;
    int d;
    r = '0;
    t = 1;
    for (int p = 0; p < 4; p++) begin
      d = tb_rec[b][p] * 2;
      if (c >= t && c < t + d) r[5 - p] = 1'b1;
      t += d;
    end
    if (c == t) r[0] = 1'b1;
    if (c >= 1 && c <= t) r[1] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts drink b and checks every cycle; optionally a stray aceptada at acc_at and cancelar at cancel_at.
  task automatic run_seq(input int b, input logic [3:0] sel, input int ncyc,
                         input int acc_at, input int cancel_at);
    logic [5:0] e6;
    seleccion = sel;
    aceptada  = 1'b1;
    step();
    aceptada  = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      e6 = (cancel_at > 0 && c > cancel_at) ? 6'd0 : modelo(b, c);
      chk($sformatf("d%0d_c%0d_salidas", b, c), {1'b0, salidas()},
          {1'b0, e6, (acc_at > 0 && c == acc_at + 1)});
      chk($sformatf("d%0d_c%0d_bebida", b, c), {6'd0, bebida_actual},
          e6[1] ? 8'(b) : 8'd0);
      aceptada = (c == acc_at);
      if (c == acc_at) seleccion = 4'b0001;
      cancelar = (c == cancel_at);
      step();
    end
    aceptada = 1'b0;
    cancelar = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("reset_salidas", {1'b0, salidas()}, 8'd0);
    chk("reset_estado", {5'd0, estado_dbg}, {5'd0, IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // Expreso, then mocaccino
    run_seq(0, 4'b0001, 13, 0, 0);
    run_seq(3, 4'b1000, 17, 0, 0);

    // Invalid selections
    seleccion = 4'b0110; aceptada = 1'b1; step(); aceptada = 1'b0;
    chk("inval_0110_pulso", {1'b0, salidas()}, 8'b0000_0001);
    step();
    chk("inval_0110_fin", {1'b0, salidas()}, 8'd0);
    seleccion = 4'b0000; aceptada = 1'b1; step(); aceptada = 1'b0;
    chk("inval_0000_pulso", {1'b0, salidas()}, 8'b0000_0001);
    chk("inval_0000_estado", {5'd0, estado_dbg}, {5'd0, IDLE});
    step();

    // Cancel together with aceptada in IDLE is refused
    seleccion = 4'b0001; aceptada = 1'b1; cancelar = 1'b1; step();
    aceptada = 1'b0; cancelar = 1'b0;
    chk("cancel_acept_idle", {1'b0, salidas()}, 8'b0000_0001);
    step();

    // Capuccino with a stray aceptada during agua (cycle 7)
    run_seq(2, 4'b0100, 15, 7, 0);
    // Con leche cancelled in leche (cycle 8)
    run_seq(1, 4'b0010, 14, 0, 8);
    // Expreso with aceptada during LISTO (cycle 11)
    run_seq(0, 4'b0001, 13, 11, 0);

    // Asynchronous reset mid-run
    seleccion = 4'b0001; aceptada = 1'b1; step(); aceptada = 1'b0;
    step(); step();
    chk("pre_rst_cafe", {1'b0, salidas()}, 8'b0100_0100);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_salidas", {1'b0, salidas()}, 8'd0);
    chk("rst_async_bebida", {6'd0, bebida_actual}, 8'd0);
    @(negedge clk) rst = 1'b0;
    step();

`ifdef CAFE_TAZA_EN
    // No cup at acceptance is refused
    taza_presente = 1'b0;
    seleccion = 4'b0001; aceptada = 1'b1; step(); aceptada = 1'b0;
    chk("taza_ausente_rech", {1'b0, salidas()}, 8'b0000_0001);
    taza_presente = 1'b1;
    step();
    // Expreso with the cup removed during cycles 3..7
    seleccion = 4'b0001; aceptada = 1'b1; step(); aceptada = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      logic [6:0] e;
      taza_presente = !(c >= 3 && c <= 7);
      #1;
      e = '0;
      e[6] = (c >= 1 && c <= 2) || (c >= 8 && c <= 11);
      e[5] = (c >= 12 && c <= 15);
      e[2] = (c >= 1 && c <= 16);
      e[1] = (c == 16);
      chk($sformatf("taza_c%0d", c), {1'b0, salidas()}, {1'b0, e});
      step();
    end
    taza_presente = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
